// File: rtl/pmu_sipo_pkg.sv
// Block-width constants shared by the sipo/piso pair and their benches.
package pmu_sipo_pkg;

  localparam int SIPO_WIDTH_DEF = 128;

  // A one-bit counter is the minimum, even for WIDTH=2.
  function automatic int cnt_w(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/sipo_bit_cnt.sv
// Bit position counter for the sipo assembler; last_o flags the final bit of a block.
module sipo_bit_cnt #(
  parameter int WIDTH = 128,
  parameter int CNT_W = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic last_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt;

  assign last_o = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= last_o ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sipo.sv
// Serial-in parallel-out block assembler, MSB first, double-buffered behind a valid/ack port.
// Optional sticky overflow flag ovf_o is built when SIPO_OVF_FLAG_EN is defined.
module sipo
  import pmu_sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             data_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ack_i
`ifdef SIPO_OVF_FLAG_EN
  ,
  output logic             ovf_o
`endif
);

  localparam int CNT_W = cnt_w(WIDTH);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic [WIDTH-1:0] hold;
  logic             sr_full;
  logic             valid_q;
  logic             accept;
  logic             last;
  logic             complete;
  logic             hold_free;

  assign accept    = en & ~sr_full;
  assign complete  = accept & last;
  assign hold_free = ~valid_q | ack_i;
  assign sr_next   = {sr[WIDTH-2:0], data_i};

  // ready_o is the inverse of a flop so the serial side sees no path from en or ack_i.
  assign ready_o = ~sr_full;
  assign data_o  = hold;
  assign valid_o = valid_q;

  sipo_bit_cnt #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .inc    (accept & ~clr),
    .last_o (last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr <= '0;
    end else if (!clr && accept) begin
      sr <= sr_next;
    end
  end

  // A completed word goes straight to hold when it is free; otherwise it parks in sr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold    <= '0;
      sr_full <= 1'b0;
      valid_q <= 1'b0;
    end else if (clr) begin
      sr_full <= 1'b0;
      valid_q <= 1'b0;
    end else if (sr_full) begin
      if (ack_i) begin
        hold    <= sr;
        sr_full <= 1'b0;
      end
    end else if (complete) begin
      if (hold_free) begin
        hold    <= sr_next;
        valid_q <= 1'b1;
      end else begin
        sr_full <= 1'b1;
      end
    end else if (ack_i) begin
      valid_q <= 1'b0;
    end
  end

`ifdef SIPO_OVF_FLAG_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else if (clr) begin
      ovf_q <= 1'b0;
    end else if (en && sr_full) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf_o = ovf_q;
`endif

endmodule

// File: tb/tb_sipo.sv
// Scoreboard bench for sipo: expected blocks are queued as they are shifted in and popped on delivery.
module tb_sipo;
  import pmu_sipo_pkg::*;

  localparam int W = SIPO_WIDTH_DEF;
  localparam logic [W-1:0] BLK_A = 128'habcdef0123456789abcdef0123456789;
  localparam logic [W-1:0] BLK_B = 128'h9876543210fedcba9876543210fedcba;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         clr = 1'b0;
  logic         en = 1'b0;
  logic         data_i = 1'b0;
  logic         ready_o;
  logic [W-1:0] data_o;
  logic         valid_o;
  logic         ack_i = 1'b0;
`ifdef SIPO_OVF_FLAG_EN
  logic         ovf_o;
`endif

  int checks = 0;
  int failures = 0;
  logic [W-1:0] sb[$];
  logic [W-1:0] exp_w;

  sipo #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .en      (en),
    .data_i  (data_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .ack_i   (ack_i)
`ifdef SIPO_OVF_FLAG_EN
    ,
    .ovf_o   (ovf_o)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit expired, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_range(input logic [W-1:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      en     = 1'b1;
      data_i = w[i];
      tick();
    end
    en = 1'b0;
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] r;
    for (int k = 0; k < W / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic test_reset();
    logic [W-1:0] w;
    rst = 1'b0;
    tick();
    tick();
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", ready_o); end
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    checks++; if (data_o !== '0) begin failures++; $display("FAIL reset_data: got %h want 0", data_o); end
`ifdef SIPO_OVF_FLAG_EN
    checks++; if (ovf_o !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b want 0", ovf_o); end
`endif
    rst = 1'b1;
    tick();
    // Abandon a block at bit 40 with an asynchronous reset.
    w = rand_word();
    shift_range(w, W - 1, W - 40);
    #2 rst = 1'b0;
    #1;
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL midreset_ready: got %b want 1", ready_o); end
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL midreset_valid: got %b want 0", valid_o); end
    checks++; if (data_o !== '0) begin failures++; $display("FAIL midreset_data: got %h want 0", data_o); end
    tick();
    rst = 1'b1;
    tick();
    w = rand_word();
    sb.push_back(w);
    shift_range(w, W - 1, 0);
    checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL fresh_valid: got %b want 1", valid_o); end
    exp_w = sb.pop_front();
    checks++; if (data_o !== exp_w) begin failures++; $display("FAIL fresh_data: got %h want %h", data_o, exp_w); end
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL fresh_ack_valid: got %b want 0", valid_o); end
  endtask

  task automatic test_single();
    sb.push_back(BLK_A);
    shift_range(BLK_A, W - 1, 1);
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL single_early_valid: got %b want 0", valid_o); end
    shift_range(BLK_A, 0, 0);
    checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL single_valid: got %b want 1", valid_o); end
    checks++; if (data_o !== sb[0]) begin failures++; $display("FAIL single_data: got %h want %h", data_o, sb[0]); end
  endtask

  task automatic test_stall();
    sb.push_back(BLK_B);
    shift_range(BLK_B, W - 1, 1);
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL stall_ready_before: got %b want 1", ready_o); end
    shift_range(BLK_B, 0, 0);
    checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL stall_ready: got %b want 0", ready_o); end
    checks++; if (data_o !== sb[0]) begin failures++; $display("FAIL stall_data_held: got %h want %h", data_o, sb[0]); end
    tick();
    checks++; if (data_o !== sb[0]) begin failures++; $display("FAIL stall_data_stable: got %h want %h", data_o, sb[0]); end
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    void'(sb.pop_front());
    checks++; if (data_o !== sb[0]) begin failures++; $display("FAIL stall_reload_data: got %h want %h", data_o, sb[0]); end
    checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL stall_reload_valid: got %b want 1", valid_o); end
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL stall_ready_return: got %b want 1", ready_o); end
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    void'(sb.pop_front());
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL stall_drain_valid: got %b want 0", valid_o); end
  endtask

  task automatic test_streaming();
    logic [W-1:0] w;
    int pulses = 0;
    ack_i = 1'b1;
    for (int b = 0; b < 3; b++) begin
      w = rand_word();
      sb.push_back(w);
      for (int i = W - 1; i >= 0; i--) begin
        en     = 1'b1;
        data_i = w[i];
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL stream_ready: blk %0d bit %0d got %b want 1", b, i, ready_o); end
        tick();
        checks++; if (valid_o !== (i == 0)) begin failures++; $display("FAIL stream_valid: blk %0d bit %0d got %b want %b", b, i, valid_o, (i == 0)); end
        if (valid_o === 1'b1) begin
          pulses++;
          if (sb.size() == 0) begin
            checks++; failures++; $display("FAIL stream_sb_empty: got unexpected block %h want none", data_o);
          end else begin
            exp_w = sb.pop_front();
            checks++; if (data_o !== exp_w) begin failures++; $display("FAIL stream_data: got %h want %h", data_o, exp_w); end
          end
        end
      end
    end
    en = 1'b0;
    tick();
    ack_i = 1'b0;
    checks++; if (pulses !== 3) begin failures++; $display("FAIL stream_pulses: got %0d want 3", pulses); end
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL stream_end_valid: got %b want 0", valid_o); end
  endtask

  task automatic test_clr();
    logic [W-1:0] ones;
    ones = '1;
    shift_range(rand_word(), W - 1, W - 60);
    clr    = 1'b1;
    en     = 1'b1;
    data_i = 1'b0;
    tick();
    clr = 1'b0;
    en  = 1'b0;
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL clr_valid: got %b want 0", valid_o); end
    sb.push_back(ones);
    shift_range(ones, W - 1, 1);
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL clr_early_valid: got %b want 0", valid_o); end
    shift_range(ones, 0, 0);
    checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL clr_valid_after: got %b want 1", valid_o); end
    exp_w = sb.pop_front();
    checks++; if (data_o !== exp_w) begin failures++; $display("FAIL clr_data: got %h want %h", data_o, exp_w); end
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
  endtask

  task automatic test_overflow();
    logic [W-1:0] w;
    sb.push_back(BLK_A);
    shift_range(BLK_A, W - 1, 0);
    sb.push_back(BLK_B);
    shift_range(BLK_B, W - 1, 0);
    checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL ovf_ready: got %b want 0", ready_o); end
`ifdef SIPO_OVF_FLAG_EN
    checks++; if (ovf_o !== 1'b0) begin failures++; $display("FAIL ovf_pre: got %b want 0", ovf_o); end
`endif
    en     = 1'b1;
    data_i = 1'b1;
    tick();
`ifdef SIPO_OVF_FLAG_EN
    checks++; if (ovf_o !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b want 1", ovf_o); end
`endif
    for (int k = 0; k < 5; k++) begin
      data_i = k[0];
      tick();
    end
    en = 1'b0;
    exp_w = sb.pop_front();
    checks++; if (data_o !== exp_w) begin failures++; $display("FAIL ovf_data_a: got %h want %h", data_o, exp_w); end
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    exp_w = sb.pop_front();
    checks++; if (data_o !== exp_w) begin failures++; $display("FAIL ovf_data_b: got %h want %h", data_o, exp_w); end
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    // Dropped bits must not have disturbed the bit count.
    w = rand_word();
    sb.push_back(w);
    shift_range(w, W - 1, 0);
    exp_w = sb.pop_front();
    checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL ovf_next_valid: got %b want 1", valid_o); end
    checks++; if (data_o !== exp_w) begin failures++; $display("FAIL ovf_next_data: got %h want %h", data_o, exp_w); end
`ifdef SIPO_OVF_FLAG_EN
    checks++; if (ovf_o !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b want 1", ovf_o); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (ovf_o !== 1'b0) begin failures++; $display("FAIL ovf_clr: got %b want 0", ovf_o); end
`else
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_streaming();
    test_clr();
    test_overflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
